uart_tx_feeder: RTL

- Byte buffer and scheduler sitting directly upstream of uart_tx.
- Accepts bytes from the XINTF-side write logic into a FIFO.
- Pops bytes one at a time and launches each with a single-cycle tx_trig, paced by uart_tx's tx_idle.
- Decouples bursty host writes from the slow serial line.

---
 rtl/uart_tx_feeder.sv | 72 +++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO byte buffer that paces single-cycle launches into uart_tx
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int BUSY_TO = 8,
  parameter int GAP_CYC = 0
) (
  input  logic          clk50M,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          tx_trig,
  output logic [7:0]    tx_data,
  input  logic          tx_idle,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_BUSY, WAIT_IDLE, GAP} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] tmr;
  logic wr_ok, pop;
  logic [AW:0] count_nxt;
  assign wr_ok = wr_en && !full;
  assign pop = state == IDLE && !empty && tx_idle;
  assign count_nxt = (wr_ok && !pop) ? count + 1'b1 : (!wr_ok && pop) ? count - 1'b1 : count;
  assign tx_trig = state == TRIG;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = pop ? TRIG : IDLE;
      TRIG:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: state_nxt = (!tx_idle || tmr == 16'(BUSY_TO - 1)) ? WAIT_IDLE : WAIT_BUSY;
      WAIT_IDLE: state_nxt = tx_idle ? (GAP_CYC > 0 ? GAP : IDLE) : WAIT_IDLE;
      GAP:       state_nxt = tmr == 16'(GAP_CYC - 1) ? IDLE : GAP;
      default:   state_nxt = IDLE;
    endcase
  end
  // tmr restarts on entry to each timed state since WAIT_BUSY and GAP are never adjacent
  always_ff @(posedge clk50M or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
      tx_data <= '0;
      tmr <= '0;
    end else begin
      state <= state_nxt;
      tmr <= (state == WAIT_BUSY || state == GAP) ? tmr + 1'b1 : '0;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      count <= count_nxt;
      full <= count_nxt == (AW+1)'(DEPTH);
      empty <= count_nxt == '0;
      overflow <= (wr_en && full) || (overflow && !ovf_clr);
    end
  always_ff @(posedge clk50M)
    if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule
